// File: rtl/mul_pkg.sv
// Shared constants and helpers for the multiplier family of blocks.
package mul_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_NREQ  = 4;

  // Minimum number of bits needed to encode n distinct values.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/rr_arb.sv
// Round-robin arbiter: one-hot grant searching upward from ptr; the winner
// becomes lowest priority on the next arbitration.
module rr_arb
  import mul_pkg::*;
#(
  parameter int N = DEF_NREQ
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         en,
  output logic [N-1:0] gnt
);

  localparam int PW = clog2(N);

  logic [PW-1:0] ptr;
  logic [PW-1:0] ptr_nxt;
  logic          found;
  int            idx;

  // NOTE: every variable gets a default before any branch so no path leaves a
  // value unassigned, which would otherwise infer a latch.
  always_comb begin
    gnt     = '0;
    ptr_nxt = ptr;
    found   = 1'b0;
    idx     = 0;
    if (en) begin
      for (int k = 0; k < N; k++) begin
        idx = int'(ptr) + k;
        if (idx >= N) idx = idx - N;
        if (!found && req[idx]) begin
          found    = 1'b1;
          gnt[idx] = 1'b1;
          ptr_nxt  = (idx == N - 1) ? '0 : PW'(idx + 1);
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge inputs, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (found) begin
      ptr <= ptr_nxt;
    end
  end

endmodule

// File: rtl/mul_unsigned_share.sv
// Shared unsigned multiplier: round-robin front end, operand register (S1),
// combinational multiply, output register (S2) tagged with requester id.
module mul_unsigned_share
  import mul_pkg::*;
#(
  parameter  int WIDTH = DEF_WIDTH,
  parameter  int NREQ  = DEF_NREQ,
  localparam int IDW   = clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [2*WIDTH-1:0]    rsp_z,
  output logic [IDW-1:0]        rsp_id
);

  localparam int ZW = 2 * WIDTH;

  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [IDW-1:0]   s1_id;
  logic             s1_adv;
  logic             s2_adv;
  logic [NREQ-1:0]  gnt;
  logic             any_gnt;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [IDW-1:0]   sel_id;
  logic [ZW-1:0]    prod;

  assign s2_adv = !rsp_valid || rsp_ready;
  assign s1_adv = !s1_valid || s2_adv;

  // Gating with rst_n keeps req_ready low while reset is held, since the
  // emptied pipeline would otherwise look ready to accept.
  rr_arb #(.N(NREQ)) u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req_valid),
    .en    (s1_adv && rst_n),
    .gnt   (gnt)
  );

  assign req_ready = gnt;
  assign any_gnt   = |gnt;

  always_comb begin
    sel_a  = '0;
    sel_b  = '0;
    sel_id = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        sel_a  = req_a[i*WIDTH +: WIDTH];
        sel_b  = req_b[i*WIDTH +: WIDTH];
        sel_id = IDW'(i);
      end
    end
  end

  assign prod = ZW'(s1_a) * ZW'(s1_b);

  // NOTE: the data registers are reset too, so the outputs read as zero after
  // reset rather than holding stale operands or products.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_id    <= '0;
    end else if (s1_adv) begin
      s1_valid <= any_gnt;
      if (any_gnt) begin
        s1_a  <= sel_a;
        s1_b  <= sel_b;
        s1_id <= sel_id;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_z     <= '0;
      rsp_id    <= '0;
    end else if (s2_adv) begin
      rsp_valid <= s1_valid;
      if (s1_valid) begin
        rsp_z  <= prod;
        rsp_id <= s1_id;
      end
    end
  end

endmodule

// File: tb/tb_mul_unsigned_share.sv
// Scoreboard bench for mul_unsigned_share: per-requester operand queues drive
// the DUT; accepted operands push expected products, responses pop them.
module tb_mul_unsigned_share;

  localparam int W   = 8;
  localparam int N   = 4;
  localparam int IDW = 2;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
  } op_t;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [2*W-1:0] z;
  } rsp_t;

  logic           clk       = 1'b0;
  logic           rst_n     = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a     = '0;
  logic [N*W-1:0] req_b     = '0;
  logic           rsp_valid;
  logic           rsp_ready = 1'b0;
  logic [2*W-1:0] rsp_z;
  logic [IDW-1:0] rsp_id;

  op_t          opq[N][$];
  rsp_t         sb[$];
  int           glog[$];
  logic [N-1:0] acc_mask = '0;
  int           checks = 0;
  int           errors = 0;

  logic           prev_stall = 1'b0;
  logic [2*W-1:0] prev_z     = '0;
  logic [IDW-1:0] prev_id    = '0;
  logic [W-1:0]   ma, mb;
  rsp_t           mexp;

  mul_unsigned_share dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_z     (rsp_z),
    .rsp_id    (rsp_id)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Monitor on the falling edge: inputs only change just after a rising edge,
  // so what is seen here is what the next rising edge will transfer.
  always @(negedge clk) begin
    if (!rst_n) begin
      acc_mask   = '0;
      prev_stall = 1'b0;
    end else begin
      acc_mask = req_valid & req_ready;
      checks++;
      if ((req_ready & ~req_valid) != '0 || $countones(req_ready) > 1) begin
        errors++;
        $display("FAIL grant_onehot req_ready=%b req_valid=%b", req_ready, req_valid);
      end
      if (prev_stall) begin
        checks++;
        if (rsp_valid !== 1'b1 || rsp_z !== prev_z || rsp_id !== prev_id) begin
          errors++;
          $display("FAIL rsp_stable got v=%b z=%0d id=%0d want v=1 z=%0d id=%0d",
                   rsp_valid, rsp_z, rsp_id, prev_z, prev_id);
        end
      end
      if (rsp_valid && rsp_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL rsp_unexpected got z=%0d id=%0d want none", rsp_z, rsp_id);
        end else begin
          mexp = sb.pop_front();
          if (rsp_id !== mexp.id || rsp_z !== mexp.z) begin
            errors++;
            $display("FAIL rsp_data got z=%0d id=%0d want z=%0d id=%0d",
                     rsp_z, rsp_id, mexp.z, mexp.id);
          end
        end
      end
      for (int i = 0; i < N; i++) begin
        if (acc_mask[i]) begin
          ma   = req_a[i*W +: W];
          mb   = req_b[i*W +: W];
          mexp = '{id: IDW'(i), z: 16'(int'(ma) * int'(mb))};
          sb.push_back(mexp);
          glog.push_back(i);
        end
      end
      prev_stall = rsp_valid && !rsp_ready;
      prev_z     = rsp_z;
      prev_id    = rsp_id;
    end
  end

  // Requester model: hold the head operand until it is accepted.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < N; i++) begin
      if (acc_mask[i] && opq[i].size() > 0) void'(opq[i].pop_front());
    end
    acc_mask = '0;
    for (int i = 0; i < N; i++) begin
      if (opq[i].size() > 0) begin
        req_valid[i]       = 1'b1;
        req_a[i*W +: W]    = opq[i][0].a;
        req_b[i*W +: W]    = opq[i][0].b;
      end else begin
        req_valid[i]       = 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input int i, input int a, input int b);
    op_t o;
    o.a = W'(a);
    o.b = W'(b);
    opq[i].push_back(o);
  endtask

  function automatic bit busy();
    bit any;
    any = (sb.size() != 0) || rsp_valid || (req_valid != '0);
    for (int i = 0; i < N; i++) if (opq[i].size() != 0) any = 1'b1;
    return any;
  endfunction

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while (busy() && n < budget) begin
      step();
      n++;
    end
    checks++;
    if (busy()) begin
      errors++;
      $display("FAIL %s_drain_timeout got busy after %0d cycles want idle", name, n);
    end
  endtask

  task automatic run_one(input int i, input int a, input int b,
                         output logic [2*W-1:0] z, output logic [IDW-1:0] id,
                         output bit ok);
    int n;
    push(i, a, b);
    n = 0;
    while (!rsp_valid && n < 20) begin
      step();
      n++;
    end
    ok = rsp_valid;
    z  = rsp_z;
    id = rsp_id;
    wait_drain("run_one", 20);
  endtask

  task automatic check_glog(input string name, input int exp_q[$]);
    int bad;
    bad = 0;
    if (glog.size() != exp_q.size()) bad = 1;
    else for (int k = 0; k < exp_q.size(); k++) if (glog[k] != exp_q[k]) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s got %p want %p", name, glog, exp_q);
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    rsp_ready = 1'b1;
    step();
    checks++;
    if (rsp_valid !== 1'b0 || rsp_z !== '0 || rsp_id !== '0) begin
      errors++;
      $display("FAIL reset_outputs got v=%b z=%0d id=%0d want 0 0 0", rsp_valid, rsp_z, rsp_id);
    end
    push(1, 2, 2);
    step();
    checks++;
    if (req_ready !== '0) begin
      errors++;
      $display("FAIL reset_ready got %b want 0000 (req_valid=%b)", req_ready, req_valid);
    end
    opq[1].delete();
    step();
    rst_n = 1'b1;
    step();
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== '0) begin
      errors++;
      $display("FAIL after_reset_idle got v=%b ready=%b want 0 0000", rsp_valid, req_ready);
    end
  endtask

  task automatic test_single();
    int n;
    glog.delete();
    push(0, 3, 5);
    n = 0;
    while (!req_ready[0] && n < 20) begin
      step();
      n++;
    end
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL single_grant got %b want 0001", req_ready);
    end
    step();
    checks++;
    if (req_ready !== 4'b0000 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_mid got ready=%b v=%b want 0000 0", req_ready, rsp_valid);
    end
    step();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_z !== 16'd15 || rsp_id !== 2'd0) begin
      errors++;
      $display("FAIL single_rsp got v=%b z=%0d id=%0d want 1 15 0", rsp_valid, rsp_z, rsp_id);
    end
    wait_drain("single", 20);
  endtask

  task automatic test_extremes();
    logic [2*W-1:0] z;
    logic [IDW-1:0] id;
    bit ok;
    run_one(3, 255, 255, z, id, ok);
    checks++;
    if (!ok || z !== 16'd65025 || id !== 2'd3) begin
      errors++;
      $display("FAIL ext_max got v=%b z=%0d id=%0d want 1 65025 3", ok, z, id);
    end
    run_one(3, 0, 200, z, id, ok);
    checks++;
    if (!ok || z !== 16'd0 || id !== 2'd3) begin
      errors++;
      $display("FAIL ext_zero got v=%b z=%0d id=%0d want 1 0 3", ok, z, id);
    end
    run_one(3, 1, 255, z, id, ok);
    checks++;
    if (!ok || z !== 16'd255 || id !== 2'd3) begin
      errors++;
      $display("FAIL ext_one got v=%b z=%0d id=%0d want 1 255 3", ok, z, id);
    end
  endtask

  task automatic test_fairness();
    int n, gaps;
    int exp_q[$];
    glog.delete();
    rsp_ready = 1'b1;
    for (int r = 0; r < 6; r++)
      for (int i = 0; i < N; i++) push(i, 17 * i + r + 1, 3 * r + i + 2);
    n = 0;
    while (!rsp_valid && n < 20) begin
      step();
      n++;
    end
    gaps = 0;
    for (int k = 0; k < 24; k++) begin
      if (!rsp_valid) gaps++;
      step();
    end
    checks++;
    if (gaps != 0) begin
      errors++;
      $display("FAIL fair_throughput got %0d bubbles want 0", gaps);
    end
    wait_drain("fairness", 40);
    for (int k = 0; k < 24; k++) exp_q.push_back(k % N);
    check_glog("fair_order", exp_q);
  endtask

  task automatic test_back_to_back();
    int n;
    int exp_q[$];
    glog.delete();
    rsp_ready = 1'b0;
    for (int r = 0; r < 3; r++)
      for (int i = 0; i < N; i++) push(i, 29 * i + 7 * r + 3, 11 * r + 5 * i + 1);
    n = 0;
    while (req_valid == '0 && n < 5) begin
      step();
      n++;
    end
    repeat (5) step();
    checks++;
    if (glog.size() != 2 || req_ready !== '0 || rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_stall got accepts=%0d ready=%b v=%b want 2 0000 1",
               glog.size(), req_ready, rsp_valid);
    end
    rsp_ready = 1'b1;
    wait_drain("backpressure", 40);
    for (int k = 0; k < 12; k++) exp_q.push_back(k % N);
    check_glog("bp_order", exp_q);
  endtask

  task automatic test_ptr_wrap();
    glog.delete();
    push(3, 9, 9);
    wait_drain("wrap_first", 20);
    repeat (3) step();
    push(0, 4, 6);
    push(1, 8, 12);
    push(3, 100, 3);
    wait_drain("wrap_second", 20);
    check_glog("ptr_wrap_order", '{3, 0, 1, 3});
  endtask

  task automatic test_reset_mid();
    int n;
    glog.delete();
    rsp_ready = 1'b0;
    push(0, 10, 11);
    push(1, 12, 13);
    push(2, 14, 15);
    n = 0;
    while (glog.size() < 2 && n < 20) begin
      step();
      n++;
    end
    checks++;
    if (rsp_valid !== 1'b1 || req_valid[2] !== 1'b1) begin
      errors++;
      $display("FAIL rmid_full got v=%b req_valid=%b want 1 x1xx", rsp_valid, req_valid);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== '0) begin
      errors++;
      $display("FAIL rmid_async got v=%b ready=%b want 0 0000", rsp_valid, req_ready);
    end
    for (int i = 0; i < N; i++) opq[i].delete();
    sb.delete();
    glog.delete();
    step();
    step();
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    push(2, 7, 9);
    wait_drain("reset_mid", 20);
    check_glog("rmid_grant", '{2});
  endtask

  initial begin
    test_reset();
    test_single();
    test_extremes();
    test_fairness();
    test_back_to_back();
    test_ptr_wrap();
    test_reset_mid();
    repeat (3) step();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_left got %0d entries want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
